// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetches words from instruction memory over a
// req/ack handshake, buffers {pc, instr} pairs in a small FIFO and presents the
// head to the decoders over valid/ready. Branch redirects flush the FIFO and
// drop any in-flight wrong-path fetch.
module instr_fetch_unit #(
    parameter int              PC_W      = 8,
    parameter int              INSTR_W   = 32,
    parameter int              BUF_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         op,
    output logic [5:0]         fcode,
    output logic [PC_W-1:0]    pc_out,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [PC_W-1:0]  STEP_C  = PC_W'(4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PC_W-1:0]    pc_mem    [BUF_DEPTH];
    logic [INSTR_W-1:0] instr_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_after;
    logic [PC_W-1:0]    target_pc;
    logic               push, pop, mid_request;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    // A redirect squashes both the pop and any returning word in its cycle.
    assign push        = (state == REQ) && imem_ack && !redirect;
    assign pop         = dec_valid && dec_ready && !redirect;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    assign mid_request = imem_req && !imem_ack;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; redirect takes priority over normal fetch flow.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (redirect || (count < DEPTH_C)) state_nxt = REQ;
            end
            REQ: begin
                if (redirect)      state_nxt = imem_ack ? REQ : DISCARD;
                else if (imem_ack) state_nxt = (count_after < DEPTH_C) ? REQ : IDLE;
            end
            DISCARD: begin
                // The wrong-path word is dropped; a fresh redirect in the same
                // cycle simply becomes the new fetch address.
                if (imem_ack) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: a request is outstanding in every non-idle state.
    always_comb begin
        imem_req = (state != IDLE);
    end

    // Fetch address and pending redirect target; the address never moves while
    // a request is waiting for its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr <= RESET_PC;
            target_pc <= RESET_PC;
        end else if (redirect) begin
            target_pc <= redirect_pc;
            if (!mid_request) imem_addr <= redirect_pc;
        end else if (push) begin
            imem_addr <= imem_addr + STEP_C;
        end else if ((state == DISCARD) && imem_ack) begin
            imem_addr <= target_pc;
        end
    end

    // FIFO control: pointers and occupancy, cleared on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_after;
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= imem_addr;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    // Head presentation; all fields read as zero when the FIFO is empty.
    always_comb begin
        dec_valid = (count != '0);
        instr     = dec_valid ? instr_mem[rd_ptr] : '0;
        pc_out    = dec_valid ? pc_mem[rd_ptr]    : '0;
        op        = instr[INSTR_W-1 -: 6];
        fcode     = instr[5:0];
    end

endmodule
